// File: rtl/eth_rx_frame_buf_ctrl.sv
// Receive frame buffer controller: stores MAC bytes in an external dual-port RAM,
// commits good frames to a length queue and replays them as a ready/valid stream.
module eth_rx_frame_buf_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int LEN_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [7:0]                       in_data,
  input  logic                             in_last,
  input  logic                             in_err,
  output logic [ADDR_WIDTH-1:0]            ram_addra,
  output logic [7:0]                       ram_dia,
  output logic                             ram_wea,
  output logic [ADDR_WIDTH-1:0]            ram_addrb,
  input  logic [7:0]                       ram_dob,
  output logic                             out_valid,
  output logic [7:0]                       out_data,
  output logic                             out_last,
  input  logic                             out_ready,
  output logic [$clog2(LEN_DEPTH+1)-1:0]   frames_pending,
  output logic [15:0]                      drop_cnt,
  output logic                             drop_pulse
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(LEN_DEPTH + 1);
  localparam int QW = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
  localparam logic [PW-1:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DISCARD} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} rstate_t;

  wstate_t wstate, wstate_nx;
  rstate_t rstate, rstate_nx;

  logic [PW-1:0] wr_ptr, wr_ptr_nx, commit_ptr, commit_ptr_nx, rd_ptr, rd_next;
  logic [PW-1:0] used, push_len, remain;
  logic          full, wr_en, push, drop, pop, fire, done, lenq_full;

  logic [PW-1:0] lenq [LEN_DEPTH];
  logic [QW-1:0] q_wr, q_rd;
  logic [CW-1:0] q_cnt, pend;

  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] i);
    return (i == QW'(LEN_DEPTH - 1)) ? '0 : i + QW'(1);
  endfunction

  assign used      = wr_ptr - rd_ptr;
  assign full      = (used == CAPACITY);
  assign push_len  = wr_ptr + PW'(1) - commit_ptr;
  // A frame occupies a queue slot from commit until its last byte is handed off.
  assign lenq_full = (pend == CW'(LEN_DEPTH));

  always_comb begin
    wstate_nx     = wstate;
    wr_ptr_nx     = wr_ptr;
    commit_ptr_nx = commit_ptr;
    wr_en         = 1'b0;
    push          = 1'b0;
    drop          = 1'b0;
    case (wstate)
      W_IDLE, W_RECV: begin
        if (in_valid) begin
          if (full) begin
            wr_ptr_nx = commit_ptr;
            drop      = 1'b1;
            wstate_nx = in_last ? W_IDLE : W_DISCARD;
          end else begin
            wr_en     = 1'b1;
            wr_ptr_nx = wr_ptr + PW'(1);
            wstate_nx = W_RECV;
            if (in_last) begin
              wstate_nx = W_IDLE;
              if (!in_err && !lenq_full) begin
                push          = 1'b1;
                commit_ptr_nx = wr_ptr + PW'(1);
              end else begin
                drop      = 1'b1;
                wr_ptr_nx = commit_ptr;
              end
            end
          end
        end
      end
      W_DISCARD: if (in_valid && in_last) wstate_nx = W_IDLE;
      default:   wstate_nx = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_nx = rstate;
    pop       = 1'b0;
    fire      = 1'b0;
    done      = 1'b0;
    case (rstate)
      R_IDLE: if (q_cnt != '0) begin
        pop       = 1'b1;
        rstate_nx = R_LOAD;
      end
      R_LOAD: rstate_nx = R_STREAM;
      R_STREAM: if (out_ready) begin
        fire = 1'b1;
        if (remain == PW'(1)) begin
          done      = 1'b1;
          rstate_nx = R_IDLE;
        end
      end
      default: rstate_nx = R_IDLE;
    endcase
  end

  // Read address runs one byte ahead on a handshake so the synchronous RAM keeps up.
  assign rd_next   = rd_ptr + PW'(fire);
  assign ram_addrb = rd_next[ADDR_WIDTH-1:0];
  assign ram_addra = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_dia   = in_data;
  assign ram_wea   = wr_en & rst_n;

  assign out_valid      = (rstate == R_STREAM);
  assign out_last       = out_valid && (remain == PW'(1));
  assign out_data       = ram_dob;
  assign frames_pending = pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate     <= W_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      wstate     <= wstate_nx;
      wr_ptr     <= wr_ptr_nx;
      commit_ptr <= commit_ptr_nx;
      drop_pulse <= drop;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate <= R_IDLE;
      rd_ptr <= '0;
      remain <= '0;
    end else begin
      rstate <= rstate_nx;
      rd_ptr <= rd_next;
      if (pop)       remain <= lenq[q_rd];
      else if (fire) remain <= remain - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_wr  <= '0;
      q_rd  <= '0;
      q_cnt <= '0;
      pend  <= '0;
    end else begin
      if (push) q_wr <= q_inc(q_wr);
      if (pop)  q_rd <= q_inc(q_rd);
      q_cnt <= q_cnt + CW'(push) - CW'(pop);
      pend  <= pend + CW'(push) - CW'(done);
    end
  end

  always_ff @(posedge clk) begin
    if (push) lenq[q_wr] <= push_len;
  end

endmodule

// File: tb/tb_eth_rx_frame_buf_ctrl.sv
// Self-checking bench for eth_rx_frame_buf_ctrl: frame vector table plus
// directed sequences for overflow, queue-full, backpressure and reset.
module tb_eth_rx_frame_buf_ctrl;

  localparam int AW = 11;
  localparam int LD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_last, in_err, out_ready;
  logic [7:0]    in_data, ram_dia, out_data;
  logic [7:0]    ram_dob = 8'h00;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic          ram_wea, out_valid, out_last, drop_pulse;
  logic [2:0]    frames_pending;
  logic [15:0]   drop_cnt;

  eth_rx_frame_buf_ctrl #(.ADDR_WIDTH(AW), .LEN_DEPTH(LD)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_err(in_err),
    .ram_addra(ram_addra), .ram_dia(ram_dia), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_dob(ram_dob),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .frames_pending(frames_pending), .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  // synchronous-read RAM model
  logic [7:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dia;
    ram_dob <= mem[ram_addrb];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int first_valid = -1;
  int pulses = 0;
  logic [7:0] got_data [$];
  logic       got_last [$];
  logic [7:0] exp_data [$];
  logic       exp_last [$];

  typedef struct {
    int         len;
    logic [7:0] start;
    bit         err;
    int         exp_bytes;
    int         exp_drops;
  } vec_t;
  vec_t vecs [6];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int len, input logic [7:0] start, input bit err);
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(start + 8'(i));
      in_last  = (i == len - 1);
      in_err   = (i == len - 1) ? err : 1'b0;
      if (i == len - 1) last_cyc = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_err   = 1'b0;
  endtask

  task automatic waitBytes(input int n, input int budget);
    int b = budget;
    while (got_data.size() < n && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
    if (got_data.size() < n) checkOutput("timeout", got_data.size(), n);
  endtask

  task automatic clearObs();
    got_data.delete();
    got_last.delete();
    exp_data.delete();
    exp_last.delete();
    first_valid = -1;
    pulses = 0;
  endtask

  task automatic expectFrame(input int len, input logic [7:0] start);
    for (int i = 0; i < len; i++) begin
      exp_data.push_back(8'(start + 8'(i)));
      exp_last.push_back(i == len - 1);
    end
  endtask

  task automatic checkStream(input string name);
    checkOutput({name, "_count"}, got_data.size(), exp_data.size());
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checkOutput($sformatf("%s_data[%0d]", name, i), got_data[i], exp_data[i]);
      checkOutput($sformatf("%s_last[%0d]", name, i), got_last[i], exp_last[i]);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: records handshakes and checks stability across stalls.
  initial begin
    logic       stalled = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic       held_last = 1'b0;
    forever begin
      @(negedge clk);
      if (drop_pulse) pulses++;
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (stalled) begin
          checkOutput("stall_data", out_data, held_data);
          checkOutput("stall_last", out_last, held_last);
        end
        if (out_ready) begin
          got_data.push_back(out_data);
          got_last.push_back(out_last);
        end
      end
      stalled   = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
    end
  end

  initial begin
    int d0;
    vecs[0] = '{64, 8'h00, 1'b0, 64, 0};
    vecs[1] = '{20, 8'h80, 1'b1, 0,  1};
    vecs[2] = '{10, 8'h40, 1'b0, 10, 0};
    vecs[3] = '{1,  8'hA5, 1'b0, 1,  0};
    vecs[4] = '{3,  8'hF0, 1'b1, 0,  1};
    vecs[5] = '{2,  8'h10, 1'b0, 2,  0};

    // reset with input activity present
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0; in_err = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    checkOutput("rst_wea", ram_wea, 0);
    checkOutput("rst_addra", ram_addra, 0);
    checkOutput("rst_addrb", ram_addrb, 0);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_last", out_last, 0);
    checkOutput("rst_pending", frames_pending, 0);
    checkOutput("rst_dropcnt", drop_cnt, 0);
    checkOutput("rst_pulse", drop_pulse, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // frame vector table, out_ready held high
    for (int v = 0; v < 6; v++) begin
      clearObs();
      d0 = drop_cnt;
      expectFrame(vecs[v].exp_bytes, vecs[v].start);
      for (int i = 0; i < exp_last.size(); i++) exp_last[i] = (i == vecs[v].len - 1);
      applyStimulus(vecs[v].len, vecs[v].start, vecs[v].err);
      if (vecs[v].exp_bytes > 0) waitBytes(vecs[v].exp_bytes, 300);
      repeat (8) @(posedge clk); #1;
      checkStream($sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d_dropcnt", v), drop_cnt, d0 + vecs[v].exp_drops);
      checkOutput($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_drops);
      if (vecs[v].exp_bytes > 0)
        checkOutput($sformatf("vec%0d_latency", v), first_valid - last_cyc, 3);
    end

    // buffer overflow: 2500 bytes with no reader
    clearObs();
    d0 = drop_cnt;
    out_ready = 1'b0;
    applyStimulus(2500, 8'h00, 1'b0);
    repeat (8) @(posedge clk); #1;
    checkOutput("ovf_dropcnt", drop_cnt, d0 + 1);
    checkOutput("ovf_pulses", pulses, 1);
    checkOutput("ovf_pending", frames_pending, 0);
    checkOutput("ovf_nooutput", first_valid, -1);
    out_ready = 1'b1;
    clearObs();
    expectFrame(100, 8'h33);
    applyStimulus(100, 8'h33, 1'b0);
    waitBytes(100, 300);
    checkStream("ovf_next");

    // length queue full: five 8-byte frames while stalled
    repeat (4) @(posedge clk); #1;
    clearObs();
    d0 = drop_cnt;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(8, 8'(k * 16), 1'b0);
    repeat (6) @(posedge clk); #1;
    checkOutput("qfull_pending", frames_pending, 4);
    checkOutput("qfull_dropcnt", drop_cnt, d0 + 1);
    checkOutput("qfull_pulses", pulses, 1);
    for (int k = 0; k < 4; k++) expectFrame(8, 8'(k * 16));
    out_ready = 1'b1;
    waitBytes(32, 300);
    repeat (6) @(posedge clk); #1;
    checkStream("qfull");
    checkOutput("qfull_drained", frames_pending, 0);

    // alternating backpressure
    clearObs();
    expectFrame(16, 8'hC0);
    out_ready = 1'b0;
    fork
      applyStimulus(16, 8'hC0, 1'b0);
      begin
        int b = 400;
        while (got_data.size() < 16 && b > 0) begin
          out_ready = ~out_ready;
          @(posedge clk); #1;
          b--;
        end
      end
    join
    out_ready = 1'b1;
    waitBytes(16, 10);
    checkStream("toggle");

    // reset during output, then during input
    repeat (4) @(posedge clk); #1;
    clearObs();
    applyStimulus(20, 8'h20, 1'b0);
    waitBytes(5, 100);
    rst_n = 1'b0;
    #1;
    checkOutput("rstout_valid", out_valid, 0);
    checkOutput("rstout_last", out_last, 0);
    checkOutput("rstout_pending", frames_pending, 0);
    checkOutput("rstout_dropcnt", drop_cnt, 0);
    checkOutput("rstout_addrb", ram_addrb, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hE0 + 8'(i));
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("rstin_wea", ram_wea, 0);
    checkOutput("rstin_addra", ram_addra, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clearObs();
    expectFrame(4, 8'h70);
    applyStimulus(4, 8'h70, 1'b0);
    waitBytes(4, 50);
    repeat (10) @(posedge clk); #1;
    checkStream("postrst");
    checkOutput("postrst_dropcnt", drop_cnt, 0);
    checkOutput("postrst_pulses", pulses, 0);
    checkOutput("postrst_latency", first_valid - last_cyc, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_buf_ctrl.md
ETH_RX_FRAME_BUF_CTRL -- requirements
Module: eth_rx_frame_buf_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, RAM address width (buffer depth 2**ADDR_WIDTH bytes).
REQ-002 SHALL have parameter LEN_DEPTH, default 4, number of committed frames the length queue holds.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  input  1  sole clock; rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid input 1 byte strobe from MAC; in_data input 8 byte; in_last input 1 final byte of frame; in_err input 1 frame bad (sampled with in_last).
REQ-005 SHALL have RAM ports: ram_addra output ADDR_WIDTH; ram_dia output 8; ram_wea output 1; ram_addrb output ADDR_WIDTH; ram_dob input 8 (valid one clk after ram_addrb, unregistered output).
REQ-006 SHALL have stream ports: out_valid output 1; out_data output 8; out_last output 1; out_ready input 1.
REQ-007 SHALL have status ports: frames_pending output $clog2(LEN_DEPTH+1); drop_cnt output 16; drop_pulse output 1.

Function
REQ-008 SHALL keep wr_ptr, commit_ptr, rd_ptr as ADDR_WIDTH+1 bit counters; used = wr_ptr - rd_ptr (modulo 2**(ADDR_WIDTH+1)).
REQ-009 SHALL, write FSM states W_IDLE, W_RECV, W_DISCARD; no in_ready exists, input is never stalled.
REQ-010 SHALL, on in_valid with used < 2**ADDR_WIDTH in W_IDLE/W_RECV, drive ram_wea=1, ram_addra=wr_ptr[ADDR_WIDTH-1:0], ram_dia=in_data same cycle, wr_ptr++ next edge.
REQ-011 SHALL, on in_valid with used == 2**ADDR_WIDTH (full), not write, rewind wr_ptr to commit_ptr, go W_DISCARD (or stay idle if in_last), count drop.
REQ-012 SHALL, in W_DISCARD, ignore all bytes until in_last, then return to W_IDLE without further drop count.
REQ-013 SHALL commit on in_last (written) with in_err=0 and length queue not full: push length (wr_ptr+1 - commit_ptr), commit_ptr <= wr_ptr+1.
REQ-014 SHALL drop on in_last with in_err=1 or length queue full: rewind wr_ptr to commit_ptr, count drop.
REQ-015 SHALL, per drop, assert drop_pulse for exactly one cycle and increment drop_cnt, saturating at 16'hFFFF.
REQ-016 SHALL, read FSM states R_IDLE, R_LOAD, R_STREAM.
REQ-017 SHALL, in R_IDLE with queue non-empty, pop length into remain, drive ram_addrb=rd_ptr, go R_LOAD.
REQ-018 SHALL, in R_LOAD, go R_STREAM; out_valid=0.
REQ-019 SHALL, in R_STREAM, assert out_valid=1, out_data=ram_dob, out_last=(remain==1).
REQ-020 SHALL, on out_valid&out_ready, rd_ptr++, remain--, ram_addrb=rd_ptr+1 combinationally; on out_last handshake go R_IDLE.
REQ-021 SHALL, while out_ready=0, hold ram_addrb, out_data, out_last stable.
REQ-022 SHALL allow same-cycle push and pop of the length queue; frames_pending reflects both next cycle.
REQ-023 SHALL never write an address between rd_ptr and commit_ptr (unread data is never overwritten).
REQ-024 SHALL support 1-byte frames (remain=1, out_last on first byte).
REQ-025 SHALL give byte-in to earliest out_valid latency of 3 cycles after the in_last cycle (commit, pop/R_LOAD, R_STREAM).

Reset
REQ-026 SHALL, on rst_n low (any cycle, including mid-frame), clear all pointers, queue, remain, drop_cnt; FSMs to W_IDLE/R_IDLE.
REQ-027 SHALL drive during reset: out_valid=0, out_last=0, ram_wea=0, drop_pulse=0, frames_pending=0, ram_addra=ram_addrb=0.
REQ-028 SHALL discard any partial frame in progress at reset; RAM contents need not be cleared.

Verification
REQ-029 64-byte frame 0x00..0x3F, in_err=0, out_ready=1 -> out 0x00..0x3F, out_last on 0x3F, first out_valid 3 cycles after in_last.
REQ-030 20-byte frame with in_err=1 on last, then 10-byte good frame -> only the 10 bytes output; drop_cnt=1; one drop_pulse.
REQ-031 out_ready=0 with 2500-byte frame arriving -> bytes 2049+ discarded, drop_cnt=1, frames_pending=0; next 100-byte frame after drain delivered intact.
REQ-032 5 back-to-back 8-byte frames, out_ready=0 -> frames 1..4 pending=4, frame 5 dropped; release -> 32 bytes, four out_last.
REQ-033 out_ready toggled 1/0 per cycle on 16-byte frame -> correct ordered data, out_data stable while stalled.
REQ-034 rst_n low mid-frame after 7 bytes and mid-output -> outputs cleared; next 4-byte frame output 4 bytes, drop_cnt=0.
